// File: rtl/stft_framer.sv
// stft_framer: slices samples into FRAME_LEN frames advancing HOP; first beat 2 cycles after the filling accept, di_rdy low while a frame bursts.
// Optional STFT_FRAMER_PAD_LAST_EN emits one zero-padded final frame for a trailing partial hop.
module stft_framer #(
   parameter int I_BW       = 14,
   parameter int O_BW       = 14,
   parameter int FRAME_LEN  = 512,
   parameter int HOP        = 256,
   parameter int TOTAL_DATA = 15104,
   parameter int F_BW       = $clog2(TOTAL_DATA/HOP+2)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         di_en,
   input  logic [I_BW-1:0]              data_i,
   output logic                         di_rdy,
   output logic                         do_en,
   output logic [O_BW-1:0]              data_o,
   output logic [$clog2(FRAME_LEN)-1:0] samp_idx,
   output logic [F_BW-1:0]              frame_num,
   output logic                         frame_last,
   output logic                         done
);
   localparam int A_BW = $clog2(FRAME_LEN);
   localparam int V_BW = $clog2(FRAME_LEN+1);
   localparam int C_BW = $clog2(TOTAL_DATA+1);
`ifdef STFT_FRAMER_PAD_LAST_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif
   localparam logic [V_BW-1:0] FL_V   = V_BW'(FRAME_LEN);
   localparam logic [V_BW-1:0] HOP_V  = V_BW'(HOP);
   localparam logic [V_BW-1:0] KEEP_V = V_BW'(FRAME_LEN-HOP);
   localparam logic [C_BW-1:0] TOT_C  = C_BW'(TOTAL_DATA);
   localparam logic [A_BW-1:0] HOP_A  = A_BW'(HOP);
   localparam logic [A_BW-1:0] LAST_A = A_BW'(FRAME_LEN-1);

   typedef enum logic [1:0] {FILL_INIT, EMIT, FILL_HOP, DONE} state_t;

   state_t          state;
   logic [I_BW-1:0] mem [FRAME_LEN];
   logic [A_BW-1:0] wr_ptr, frame_start, rd_k, rd_addr;
   logic [C_BW-1:0] acc_cnt;
   logic [V_BW-1:0] fill_cnt, fill_nxt, valid_cnt;
   logic            rd_act, accept, last_in, frame_full;

   assign accept     = di_en && di_rdy;
   assign fill_nxt   = fill_cnt + V_BW'(1);
   assign last_in    = (acc_cnt + C_BW'(1)) == TOT_C;
   assign frame_full = (state == FILL_INIT) ? (fill_nxt == FL_V) : (fill_nxt == HOP_V);
   assign rd_addr    = frame_start + rd_k;

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL_INIT;
         wr_ptr      <= '0;
         acc_cnt     <= '0;
         fill_cnt    <= '0;
         frame_start <= '0;
         rd_k        <= '0;
         rd_act      <= 1'b0;
         valid_cnt   <= '0;
         di_rdy      <= 1'b1;
         do_en       <= 1'b0;
         data_o      <= '0;
         samp_idx    <= '0;
         frame_num   <= '0;
         frame_last  <= 1'b0;
         done        <= 1'b0;
      end else begin
         do_en      <= 1'b0;
         frame_last <= 1'b0;
         if (accept) begin
            wr_ptr   <= wr_ptr + A_BW'(1);
            fill_cnt <= fill_nxt;
            if (acc_cnt != TOT_C) acc_cnt <= acc_cnt + C_BW'(1);
         end
         case (state)
            FILL_INIT, FILL_HOP: begin
               if (accept) begin
                  if (frame_full) begin
                     state     <= EMIT;
                     di_rdy    <= 1'b0;
                     rd_act    <= 1'b1;
                     rd_k      <= '0;
                     valid_cnt <= FL_V;
                  end else if (last_in && PAD_EN) begin
                     // Short final frame: only the real samples are read back, the rest is zero.
                     state     <= EMIT;
                     di_rdy    <= 1'b0;
                     rd_act    <= 1'b1;
                     rd_k      <= '0;
                     valid_cnt <= (state == FILL_INIT) ? fill_nxt : fill_nxt + KEEP_V;
                  end else if (last_in) begin
                     state  <= DONE;
                     di_rdy <= 1'b0;
                     done   <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (rd_act) begin
                  do_en      <= 1'b1;
                  samp_idx   <= rd_k;
                  frame_last <= (rd_k == LAST_A);
                  data_o     <= ({1'b0, rd_k} < valid_cnt) ? O_BW'(mem[rd_addr]) : '0;
                  rd_k       <= rd_k + A_BW'(1);
                  if (rd_k == LAST_A) rd_act <= 1'b0;
               end
               // Leave once the final beat is on the outputs; frame n+1 starts HOP samples later.
               if (do_en && frame_last) begin
                  frame_num   <= frame_num + F_BW'(1);
                  frame_start <= frame_start + HOP_A;
                  fill_cnt    <= '0;
                  if (acc_cnt == TOT_C) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= FILL_HOP;
                     di_rdy <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
